// File: rtl/alu_mult_sequencer_pkg.sv
// Shared ALU function-select codes and flag bit positions for blocks that drive
// the 32-bit ArithmeticLogicUnit.
package alu_mult_sequencer_pkg;

    localparam logic [4:0] ALU_PASSA32 = 5'b10000;
    localparam logic [4:0] ALU_ADD32   = 5'b10100;
    localparam logic [4:0] ALU_LSL32   = 5'b11011;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mult_sequencer.sv
// Shift-and-add unsigned multiplier controller that borrows the shared ALU for
// every add and shift, with a Start/Busy/Done handshake towards the parent.
module alu_mult_sequencer
    import alu_mult_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [WIDTH-1:0]  OpA,
    input  logic [WIDTH-1:0]  OpB,
    input  logic [31:0]       ALUOut,
    output logic [31:0]       ALU_A,
    output logic [31:0]       ALU_B,
    output logic [4:0]        ALU_FunSel,
    output logic              ALU_WF,
    output logic              Busy,
    output logic              Done,
    output logic [31:0]       Product
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADD  = 3'd1,
        ST_SHF  = 3'd2,
        ST_FLG  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [31:0]        r_p;
    logic [31:0]        r_m;
    logic [WIDTH-1:0]   r_q;
    logic [4:0]         r_cnt;
    logic [31:0]        r_product;
    logic [WIDTH-1:0]   w_q_shr;
    logic               w_last;

    assign w_q_shr = r_q >> 1;
    // Stop once no multiplier bits remain, or after the WIDTH-th shift.
    assign w_last  = (w_q_shr == '0) || (r_cnt == 5'(WIDTH - 1));
    assign Product = r_product;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    w_next_state = (OpB != '0) ? ST_ADD : ST_FLG;
                end
            end
            ST_ADD:  w_next_state = ST_SHF;
            ST_SHF:  w_next_state = w_last ? ST_FLG : ST_ADD;
            ST_FLG:  w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ALU_A      = '0;
        ALU_B      = '0;
        ALU_FunSel = ALU_PASSA32;
        ALU_WF     = 1'b0;
        Busy       = (r_state != ST_IDLE);
        Done       = (r_state == ST_DONE);
        case (r_state)
            ST_ADD: begin
                if (r_q[0]) begin
                    ALU_A      = r_p;
                    ALU_B      = r_m;
                    ALU_FunSel = ALU_ADD32;
                end
            end
            ST_SHF: begin
                ALU_A      = r_m;
                ALU_FunSel = ALU_LSL32;
            end
            ST_FLG: begin
                // Pass the product through so the ALU's Z/N flags describe it.
                ALU_A      = r_p;
                ALU_FunSel = ALU_PASSA32;
                ALU_WF     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_p       <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_p   <= '0;
                        r_m   <= 32'(OpA);
                        r_q   <= OpB;
                        r_cnt <= '0;
                    end
                end
                ST_ADD: begin
                    if (r_q[0]) begin
                        r_p <= ALUOut;
                    end
                end
                ST_SHF: begin
                    r_m   <= ALUOut;
                    r_q   <= w_q_shr;
                    r_cnt <= r_cnt + 5'd1;
                end
                ST_FLG: begin
                    r_product <= r_p;
                end
                default: ;
            endcase
        end
    end

endmodule
